debounce_sync: RTL and testbench

- Upstream conditioning stage for the D latch block. Takes a raw, asynchronous, possibly bouncing level input and produces a clean, synchronized level `q`; `q` drives the latch's `d` input.
- Also emits single-cycle `rise` and `fall` pulses so downstream logic does not need its own edge detector.
- Structure: 2-flop synchronizer followed by a counter-based stability filter, controlled by a 4-state FSM.

---
 rtl/debounce_sync.sv | 136 +++++++++++++
 tb/tb_debounce_sync.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/debounce_sync.sv
// Two-flop synchronizer plus counter-qualified 4-state filter producing a clean level and edge pulses.
// Optional DEBOUNCE_GLITCH_CNT_EN adds a saturating 8-bit count of aborted waits.
module debounce_sync #(
   parameter int unsigned STABLE_CYCLES = 4,
   parameter int unsigned CNT_W         = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       d,
   output logic       q,
   output logic       rise,
   output logic       fall,
`ifdef DEBOUNCE_GLITCH_CNT_EN
   output logic [7:0] glitch_cnt,
`endif
   output logic       busy
);

   typedef enum logic [1:0] {
      StIdleLow  = 2'd0,
      StWaitHigh = 2'd1,
      StIdleHigh = 2'd2,
      StWaitLow  = 2'd3
   } state_e;

   localparam logic [CNT_W-1:0] CntLast = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

   logic             sync1, sync2;
   logic             d_s;
   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             q_d, rise_d, fall_d, busy_d;
   logic             abort;

   assign d_s = sync2;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= d;
         sync2 <= sync1;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      q_d     = q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      abort   = 1'b0;
      unique case (state_q)
         StIdleLow: begin
            if (d_s) begin
               state_d = StWaitHigh;
               cnt_d   = CntOne;
            end
         end
         StWaitHigh: begin
            // A return to the current level wins over a completing count.
            if (!d_s) begin
               state_d = StIdleLow;
               cnt_d   = '0;
               abort   = 1'b1;
            end else if (cnt_q == CntLast) begin
               state_d = StIdleHigh;
               cnt_d   = '0;
               q_d     = 1'b1;
               rise_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CntOne;
            end
         end
         StIdleHigh: begin
            if (!d_s) begin
               state_d = StWaitLow;
               cnt_d   = CntOne;
            end
         end
         StWaitLow: begin
            if (d_s) begin
               state_d = StIdleHigh;
               cnt_d   = '0;
               abort   = 1'b1;
            end else if (cnt_q == CntLast) begin
               state_d = StIdleLow;
               cnt_d   = '0;
               q_d     = 1'b0;
               fall_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CntOne;
            end
         end
         default: begin
            state_d = StIdleLow;
            cnt_d   = '0;
         end
      endcase
      busy_d = (state_d == StWaitHigh) || (state_d == StWaitLow);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdleLow;
         cnt_q   <= '0;
         q       <= 1'b0;
         rise    <= 1'b0;
         fall    <= 1'b0;
         busy    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         q       <= q_d;
         rise    <= rise_d;
         fall    <= fall_d;
         busy    <= busy_d;
      end
   end

`ifdef DEBOUNCE_GLITCH_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         glitch_cnt <= 8'd0;
      end else if (abort && (glitch_cnt != 8'hFF)) begin
         glitch_cnt <= glitch_cnt + 8'd1;
      end
   end
`else
   logic unused_abort;
   assign unused_abort = abort;
`endif

endmodule

// File: tb/tb_debounce_sync.sv
// Bench for debounce_sync: two instances (STABLE_CYCLES 4 and 2) share d/rst and are checked every
// cycle against a run-length model, plus literal checks on the directed scenarios.
module tb_debounce_sync;

   logic clk = 1'b0;
   logic rst;
   logic d;
   logic q0, rise0, fall0, busy0;
   logic q1, rise1, fall1, busy1;
`ifdef DEBOUNCE_GLITCH_CNT_EN
   logic [7:0] gc0, gc1;
`endif

   int checks = 0;
   int errors = 0;

   always #10 clk = ~clk;

   debounce_sync #(.STABLE_CYCLES(4), .CNT_W(8)) u_dut0 (
      .clk  (clk),
      .rst  (rst),
      .d    (d),
      .q    (q0),
      .rise (rise0),
      .fall (fall0),
`ifdef DEBOUNCE_GLITCH_CNT_EN
      .glitch_cnt (gc0),
`endif
      .busy (busy0)
   );

   debounce_sync #(.STABLE_CYCLES(2), .CNT_W(8)) u_dut1 (
      .clk  (clk),
      .rst  (rst),
      .d    (d),
      .q    (q1),
      .rise (rise1),
      .fall (fall1),
`ifdef DEBOUNCE_GLITCH_CNT_EN
      .glitch_cnt (gc1),
`endif
      .busy (busy1)
   );

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: q flips once d_s has disagreed with q on STABLE consecutive edges; any agreeing
   // sample while a run is open aborts it.
   int unsigned stable_n[2] = '{4, 2};
   bit   m_s1, m_s2;
   int   m_run[2];
   bit   m_q[2], m_rise[2], m_fall[2];
   int   m_glitch[2];

   always @(posedge clk or posedge rst) begin
      bit ds;
      if (rst) begin
         m_s1 = 1'b0;
         m_s2 = 1'b0;
         for (int i = 0; i < 2; i++) begin
            m_run[i] = 0; m_q[i] = 1'b0; m_rise[i] = 1'b0; m_fall[i] = 1'b0; m_glitch[i] = 0;
         end
      end else begin
         ds   = m_s2;
         m_s2 = m_s1;
         m_s1 = d;
         for (int i = 0; i < 2; i++) begin
            m_rise[i] = 1'b0;
            m_fall[i] = 1'b0;
            if (ds != m_q[i]) begin
               m_run[i]++;
               if (m_run[i] == int'(stable_n[i])) begin
                  m_q[i]    = ds;
                  m_rise[i] = ds;
                  m_fall[i] = !ds;
                  m_run[i]  = 0;
               end
            end else begin
               if (m_run[i] > 0 && m_glitch[i] < 255) m_glitch[i]++;
               m_run[i] = 0;
            end
         end
      end
   end

   always @(negedge clk) begin
      check("q0", int'(q0), int'(m_q[0]));
      check("rise0", int'(rise0), int'(m_rise[0]));
      check("fall0", int'(fall0), int'(m_fall[0]));
      check("busy0", int'(busy0), int'(m_run[0] > 0));
      check("q1", int'(q1), int'(m_q[1]));
      check("rise1", int'(rise1), int'(m_rise[1]));
      check("fall1", int'(fall1), int'(m_fall[1]));
      check("busy1", int'(busy1), int'(m_run[1] > 0));
`ifdef DEBOUNCE_GLITCH_CNT_EN
      check("glitch0", int'(gc0), m_glitch[0]);
      check("glitch1", int'(gc1), m_glitch[1]);
`endif
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      int nrise, nfall;
      rst = 1'b1;
      d   = 1'b0;
      cycles(3);
      check("reset_q", int'(q0), 0);
      check("reset_busy", int'(busy0), 0);
      #3 rst = 1'b0;
      cycles(4);

      // Clean rise: d set just after a negedge, next posedge is edge 1.
      d = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         check("rise_q0", int'(q0), (k >= 6) ? 1 : 0);
         check("rise_pulse0", int'(rise0), (k == 6) ? 1 : 0);
         check("rise_busy0", int'(busy0), (k >= 3 && k <= 5) ? 1 : 0);
         check("rise_q1", int'(q1), (k >= 4) ? 1 : 0);
      end

      // Clean fall.
      cycles(2);
      d = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         check("fall_q0", int'(q0), (k >= 6) ? 0 : 1);
         check("fall_pulse0", int'(fall0), (k == 6) ? 1 : 0);
      end
      cycles(4);

      // Short glitch: 3 periods high never moves the STABLE=4 instance.
      d = 1'b1;
      cycles(3);
      d = 1'b0;
      nrise = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         nrise += int'(rise0);
      end
      check("glitch_q0", int'(q0), 0);
      check("glitch_rise0", nrise, 0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
      check("glitch_cnt0", int'(gc0), 1);
`endif
      cycles(4);

      // STABLE=2: one-cycle pulse is ignored, two-cycle pulse flips q at edge 4.
      d = 1'b1;
      cycles(1);
      d = 1'b0;
      cycles(7);
      check("one_cyc_q1", int'(q1), 0);
      d = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         if (k == 2) d = 1'b0;
         if (k == 3) check("two_cyc_q1_e3", int'(q1), 0);
      end
      check("two_cyc_q1_e4", int'(q1), 1);
      check("two_cyc_rise1", int'(rise1), 1);
      cycles(8);

      // Bounce train then settle high.
      nrise = 0;
      nfall = 0;
      fork
         begin
            #2 d = 1'b1; #10 d = 1'b0; #20 d = 1'b1; #10 d = 1'b0; #10 d = 1'b1;
         end
         for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            nrise += int'(rise0);
            nfall += int'(fall0);
         end
      join
      check("bounce_rises", nrise, 1);
      check("bounce_falls", nfall, 0);
      check("bounce_q0", int'(q0), 1);

      // Reset mid-count: go low, then partial high count, then reset.
      d = 1'b0;
      cycles(10);
      d = 1'b1;
      cycles(3);
      check("pre_rst_busy0", int'(busy0), 1);
      #3 rst = 1'b1;
      #1;
      check("rst_q0", int'(q0), 0);
      check("rst_busy0", int'(busy0), 0);
      check("rst_rise0", int'(rise0), 0);
      d = 1'b0;
      cycles(2);
      #3 rst = 1'b0;
      nrise = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         nrise += int'(rise0) + int'(fall0);
      end
      check("post_rst_pulses", nrise, 0);

`ifdef DEBOUNCE_GLITCH_CNT_EN
      // Saturation: 300 single-cycle glitches abort on both instances.
      for (int g = 0; g < 300; g++) begin
         d = 1'b1;
         cycles(1);
         d = 1'b0;
         cycles(3);
      end
      check("sat_gc0", int'(gc0), 255);
      check("sat_gc1", int'(gc1), 255);
`endif

      // Randomized phase with mid-cycle changes and occasional reset.
      for (int it = 0; it < 1500; it++) begin
         @(negedge clk);
         if ($urandom_range(0, 59) == 0) begin
            #3 rst = 1'b1;
            @(negedge clk);
            #3 rst = 1'b0;
         end else begin
            #($urandom_range(1, 8)) d = 1'($urandom_range(0, 1));
            cycles($urandom_range(0, 6));
         end
      end
      cycles(4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
